// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter unit.
// Counter index map matches the rd_sel / ovf bit ordering.
package perf_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_e;

    localparam int CNT_CYCLE  = 0;
    localparam int CNT_RETIRE = 1;
    localparam int CNT_EVT0   = 2;

    function automatic int sel_w(input int num_evt);
        return $clog2(num_evt + 2);
    endfunction

endpackage

// File: rtl/perf_ctr_slice.sv
// One performance counter with clear, hold and sticky overflow.
// SATURATE selects stick-at-all-ones versus wrap-to-zero.
module perf_ctr_slice #(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hold,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (!hold && inc) begin
            if (&count) begin
                ovf <= 1'b1;
                if (SATURATE == 0) begin
                    count <= '0;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counters.sv
// Cycle / retire / event counters with halt and timeout freeze.
// Registered read port; prints a CPI summary in simulation on freeze.
module perf_counters
    import perf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_EVT  = 4,
    parameter int TIMEOUT  = 100000,
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halt,
    input  logic                       retire_v,
    input  logic [NUM_EVT-1:0]         evt,
    input  logic                       clr,
    input  logic [sel_w(NUM_EVT)-1:0]  rd_sel,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           cycle,
    output logic                       frozen,
    output logic                       timeout,
    output logic [NUM_EVT+1:0]         ovf
);

    localparam int NC = NUM_EVT + 2;
    localparam int SW = sel_w(NUM_EVT);
    // A TIMEOUT the cycle counter can never reach disables the compare.
    localparam bit TO_EN =
        (TIMEOUT > 0) && ($clog2(TIMEOUT + 1) <= WIDTH);
    localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);

    state_e           state;
    state_e           state_nxt;
    logic             hold;
    logic             hit;
    logic [NC-1:0]    inc;
    logic [WIDTH-1:0] cnt [NC];
    logic [WIDTH-1:0] cyc_nxt;
    logic [WIDTH-1:0] rd_mux;

    assign hold = (state == FROZEN);
    assign inc  = {evt, retire_v, 1'b1};

    for (genvar k = 0; k < NC; k++) begin : g_slice
        perf_ctr_slice #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .hold  (hold),
            .inc   (inc[k]),
            .count (cnt[k]),
            .ovf   (ovf[k])
        );
    end

    assign cycle = cnt[CNT_CYCLE];

    always_comb begin
        cyc_nxt = cnt[CNT_CYCLE] + 1'b1;
        if ((&cnt[CNT_CYCLE]) && (SATURATE != 0)) begin
            cyc_nxt = cnt[CNT_CYCLE];
        end
    end

    assign hit = TO_EN && (cyc_nxt == TO_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = RUN;
        end else if (state == RUN && (halt || hit)) begin
            state_nxt = FROZEN;
        end
    end

    always_comb begin
        frozen = (state == FROZEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (clr) begin
            timeout <= 1'b0;
        end else if (!hold && hit) begin
            timeout <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NC; k++) begin
            if (rd_sel == SW'(k)) begin
                rd_mux = cnt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

`ifndef SYNTHESIS
    // Report one edge late so the counters already hold their final values.
    logic froze_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            froze_q <= 1'b0;
        end else begin
            froze_q <= !clr && !hold && (state_nxt == FROZEN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && froze_q) begin
            $display("perf_counters: frozen cycles=%0d retired=%0d CPI=%0.2f",
                     cnt[CNT_CYCLE], cnt[CNT_RETIRE],
                     (cnt[CNT_RETIRE] == '0) ? 0.0 :
                     real'(cnt[CNT_CYCLE]) / real'(cnt[CNT_RETIRE]));
        end
    end
`endif

endmodule

// File: tb/tb_perf_counters.sv
// Self-checking bench: three configurations driven in lockstep,
// checked against an unbounded-count reference model.
module tb_perf_counters;

    localparam int NI = 3;
    localparam int NC = 5;
    localparam int PW   [NI] = '{8, 4, 4};
    localparam int PTO  [NI] = '{40, 0, 0};
    localparam bit PSAT [NI] = '{1'b1, 1'b1, 1'b0};

    logic       clk;
    logic       rst_n;
    logic       halt;
    logic       retire_v;
    logic [2:0] evt;
    logic       clr;
    logic [2:0] rd_sel;

    logic [7:0] rd_m, cyc_m;
    logic [3:0] rd_s, cyc_s, rd_w, cyc_w;
    logic       frz_m, frz_s, frz_w;
    logic       to_m, to_s, to_w;
    logic [4:0] ovf_m, ovf_s, ovf_w;

    logic [31:0] d_rd  [NI];
    logic [31:0] d_cyc [NI];
    logic        d_frz [NI];
    logic        d_to  [NI];
    logic [4:0]  d_ovf [NI];

    int unsigned mn   [NI][NC];
    bit          mfrz [NI];
    bit          mtof [NI];
    int unsigned mrd  [NI];

    int total = 0;
    int bad   = 0;

    perf_counters #(
        .WIDTH(8), .NUM_EVT(3), .TIMEOUT(40), .SATURATE(1)
    ) u_m (
        .clk(clk), .rst_n(rst_n), .halt(halt), .retire_v(retire_v),
        .evt(evt), .clr(clr), .rd_sel(rd_sel), .rd_data(rd_m),
        .cycle(cyc_m), .frozen(frz_m), .timeout(to_m), .ovf(ovf_m)
    );

    perf_counters #(
        .WIDTH(4), .NUM_EVT(3), .TIMEOUT(0), .SATURATE(1)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .halt(halt), .retire_v(retire_v),
        .evt(evt), .clr(clr), .rd_sel(rd_sel), .rd_data(rd_s),
        .cycle(cyc_s), .frozen(frz_s), .timeout(to_s), .ovf(ovf_s)
    );

    perf_counters #(
        .WIDTH(4), .NUM_EVT(3), .TIMEOUT(0), .SATURATE(0)
    ) u_w (
        .clk(clk), .rst_n(rst_n), .halt(halt), .retire_v(retire_v),
        .evt(evt), .clr(clr), .rd_sel(rd_sel), .rd_data(rd_w),
        .cycle(cyc_w), .frozen(frz_w), .timeout(to_w), .ovf(ovf_w)
    );

    assign d_rd[0]  = {24'd0, rd_m};
    assign d_rd[1]  = {28'd0, rd_s};
    assign d_rd[2]  = {28'd0, rd_w};
    assign d_cyc[0] = {24'd0, cyc_m};
    assign d_cyc[1] = {28'd0, cyc_s};
    assign d_cyc[2] = {28'd0, cyc_w};
    assign d_frz[0] = frz_m;
    assign d_frz[1] = frz_s;
    assign d_frz[2] = frz_w;
    assign d_to[0]  = to_m;
    assign d_to[1]  = to_s;
    assign d_to[2]  = to_w;
    assign d_ovf[0] = ovf_m;
    assign d_ovf[1] = ovf_s;
    assign d_ovf[2] = ovf_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned maxv(int j);
        return (32'd1 << PW[j]) - 32'd1;
    endfunction

    // Visible value of a counter that has seen n increments.
    function automatic int unsigned val(int j, int unsigned n);
        int unsigned mx;
        mx = maxv(j);
        if (n <= mx) return n;
        return PSAT[j] ? mx : n % (mx + 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NI; j++) begin
            for (int k = 0; k < NC; k++) mn[j][k] = 0;
            mfrz[j] = 1'b0;
            mtof[j] = 1'b0;
            mrd[j]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < NI; j++) begin
            mrd[j] = (rd_sel < NC) ? val(j, mn[j][rd_sel]) : 0;
            if (clr) begin
                for (int k = 0; k < NC; k++) mn[j][k] = 0;
                mfrz[j] = 1'b0;
                mtof[j] = 1'b0;
            end else if (!mfrz[j]) begin
                mn[j][0]++;
                if (retire_v) mn[j][1]++;
                for (int i = 0; i < 3; i++) begin
                    if (evt[i]) mn[j][2+i]++;
                end
                if (PTO[j] != 0 && mn[j][0] == PTO[j]) begin
                    mfrz[j] = 1'b1;
                    mtof[j] = 1'b1;
                end
                if (halt) mfrz[j] = 1'b1;
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [4:0] eo;
        for (int j = 0; j < NI; j++) begin
            eo = '0;
            for (int k = 0; k < NC; k++) eo[k] = mn[j][k] > maxv(j);
            chk($sformatf("%s_i%0d_cycle", tag, j), d_cyc[j],
                val(j, mn[j][0]));
            chk($sformatf("%s_i%0d_rd", tag, j), d_rd[j], mrd[j]);
            chk($sformatf("%s_i%0d_frozen", tag, j), 32'(d_frz[j]),
                32'(mfrz[j]));
            chk($sformatf("%s_i%0d_timeout", tag, j), 32'(d_to[j]),
                32'(mtof[j]));
            chk($sformatf("%s_i%0d_ovf", tag, j), 32'(d_ovf[j]), 32'(eo));
        end
    endtask

    task automatic step(string tag, bit h, bit r, logic [2:0] e,
                        bit c, logic [2:0] s);
        halt     = h;
        retire_v = r;
        evt      = e;
        clr      = c;
        rd_sel   = s;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        halt     = 1'b0;
        retire_v = 1'b0;
        evt      = 3'd0;
        clr      = 1'b0;
        rd_sel   = 3'd0;
        rst_n    = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 10 cycles, 4 retirements, halt on the 10th: CPI 2.5
        for (int c = 1; c <= 10; c++) begin
            step("cpi", c == 10, (c % 2 == 0) && (c <= 8), 3'd0, 1'b0, 3'd0);
        end
        step("rdret", 1'b0, 1'b0, 3'd0, 1'b0, 3'd1);
        chk("cpi_retired", d_rd[0], 32'd4);
        chk("cpi_cycles", d_cyc[0], 32'd10);
        step("hold", 1'b1, 1'b1, 3'b111, 1'b0, 3'd2);

        // clr wins over halt and an event in the same cycle
        step("clr", 1'b1, 1'b0, 3'b010, 1'b1, 3'd3);
        chk("clr_frozen", 32'(frz_m), 32'd0);

        // random traffic; u_m reaches its timeout, 4-bit units overflow
        for (int n = 0; n < 45; n++) begin
            step("rand", 1'b0, 1'($urandom), 3'($urandom), 1'b0,
                 3'($urandom));
        end
        chk("rand_to_cycle", d_cyc[0], 32'd40);
        step("rhalt", 1'b1, 1'($urandom), 3'($urandom), 1'b0, 3'd0);
        for (int n = 0; n < 5; n++) begin
            step("frzd", 1'b0, 1'b1, 3'b111, 1'b0, 3'($urandom));
        end

        // evt[0] for 20 cycles: saturate holds 15, wrap reads 4
        step("clr2", 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
        for (int n = 0; n < 20; n++) begin
            step("evt0", 1'b0, 1'b0, 3'b001, 1'b0, 3'd2);
        end
        step("evtrd", 1'b0, 1'b0, 3'd0, 1'b0, 3'd2);
        chk("sat_value", d_rd[1], 32'd15);
        chk("wrap_value", d_rd[2], 32'd4);
        chk("sat_ovf2", 32'(ovf_s[2]), 32'd1);
        chk("wrap_ovf2", 32'(ovf_w[2]), 32'd1);

        // halt coinciding with the timeout edge still flags timeout
        step("clr3", 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
        for (int n = 0; n < 39; n++) begin
            step("pre", 1'b0, 1'($urandom), 3'($urandom), 1'b0,
                 3'($urandom));
        end
        step("coin", 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("coin_timeout", 32'(to_m), 32'd1);

        // async reset mid-run at cycle 7
        step("clr4", 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
        for (int n = 0; n < 7; n++) begin
            step("run7", 1'b0, 1'($urandom), 3'($urandom), 1'b0,
                 3'($urandom));
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step("post", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        end
        chk("post_cycle", d_cyc[0], 32'd3);

        // halt with no retirements; out-of-range select reads 0
        for (int n = 0; n < 5; n++) begin
            step("noret", 1'b0, 1'b0, 3'($urandom), 1'b0, 3'd5);
        end
        step("nohalt", 1'b1, 1'b0, 3'd0, 1'b0, 3'd5);
        step("oor", 1'b0, 1'b0, 3'd0, 1'b0, 3'd7);
        chk("oor_rd", d_rd[0], 32'd0);
        step("idle", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
